instr_fetch_unit: RTL and testbench

Fetch stage feeding the control unit and datapath. Holds the PC, issues word fetches to instruction memory over a request/response interface, buffers returned instructions in a small FIFO, and presents them, with pre-split opcode/funct3/funct7_5, to the decode side through a valid/ready handshake. The unit consumes the taken-branch decision (`pc_src`) and target from execute, flushes wrong-path instructions, and drops any in-flight response.

---
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, single-outstanding imem fetch, instruction buffer, redirect/flush
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7_5
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [31:0]      fetch_pc;
  logic [31:0]      tag_pc;
  logic             outstanding;
  logic             drop;
  logic [31:0]      buf_pc    [DEPTH];
  logic [31:0]      buf_instr [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             resp;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A redirect suppresses the request so the old fetch_pc is never issued
  assign imem_req    = !rst && !outstanding && (count < DEPTH_C) && !pc_src;
  assign imem_addr   = rst ? RESET_PC : fetch_pc;
  assign accept      = imem_req && imem_ready;
  // Responses without a request in flight are ignored (covers pre-reset stragglers)
  assign resp        = imem_rvalid && outstanding;
  assign push        = resp && !drop && !pc_src;
  assign instr_valid = !rst && (count != '0);
  assign pop         = instr_valid && instr_ready;

  // Head of buffer to decode; zeroed when nothing valid is presented
  always_comb begin
    instr    = 32'h0;
    instr_pc = 32'h0;
    if (instr_valid) begin
      instr    = buf_instr[rd_ptr];
      instr_pc = buf_pc[rd_ptr];
    end
    opcode   = instr[6:0];
    funct3   = instr[14:12];
    funct7_5 = instr[30];
  end

  // Fetch PC, request tracking, wrong-path drop flag and buffer occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (resp) begin
        outstanding <= 1'b0;
      end else if (accept) begin
        outstanding <= 1'b1;
      end
      if (pc_src) begin
        // A same-cycle pop has already been taken by decode; flushing covers it
        fetch_pc <= {pc_target[31:2], 2'b00};
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        if (outstanding && !imem_rvalid) begin
          drop <= 1'b1;
        end else if (resp) begin
          drop <= 1'b0;
        end
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (resp && drop) begin
          drop <= 1'b0;
        end
        if (push) begin
          wr_ptr <= next_ptr(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= next_ptr(rd_ptr);
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (!push && pop) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  // Request address tag and buffer payload; contents are qualified by count
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_pc <= fetch_pc;
    end
    if (push) begin
      buf_pc[wr_ptr]    <= tag_pc;
      buf_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  bit          pending = 0;
  int          pend_left = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] got_pc [$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_src(pc_src), .pc_target(pc_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h00} ^ 32'h4000_50B3;
  endfunction

  // Memory side: returns the accepted word mem_lat cycles after acceptance
  task automatic begin_cycle();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (pending) begin
      pend_left--;
      if (pend_left == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pending     = 1'b0;
      end
    end
    #1;
  endtask

  task automatic end_cycle();
    if (instr_valid && instr_ready) got_pc.push_back(instr_pc);
    if (imem_req && imem_ready) begin
      pending   = 1'b1;
      pend_left = mem_lat;
      pend_addr = imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pending = 1'b0;
    pc_src  = 1'b0;
    rst     = 1'b1;
    begin_cycle(); end_cycle();
    begin_cycle(); end_cycle();
    rst = 1'b0;
    got_pc.delete();
  endtask

  task automatic test_reset();
    logic [31:0] z;
    z = 32'h0;
    rst = 1'b1; pc_src = 1'b0;
    begin_cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (imem_addr !== z) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, z); end
    checks++; if ({instr, instr_pc, opcode, funct3, funct7_5} !== 75'h0) begin errors++; $display("FAIL reset_outs: instr %h pc %h op %h f3 %h f7 %b want 0", instr, instr_pc, opcode, funct3, funct7_5); end
    end_cycle();
    begin_cycle(); end_cycle();
    rst = 1'b0;
    begin_cycle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== z) begin errors++; $display("FAIL first_req: req %b addr %h want 1 %h", imem_req, imem_addr, z); end
    end_cycle();
  endtask

  task automatic test_basic_fetch();
    logic [31:0] w;
    mem_lat = 1; instr_ready = 1'b1; imem_ready = 1'b1;
    do_reset();
    w = mem_word(32'h0);
    for (int c = 0; c < 7; c++) begin
      begin_cycle();
      checks++;
      if (imem_req !== ((c % 2) == 0)) begin errors++; $display("FAIL basic_req c%0d: got %b want %b", c, imem_req, (c % 2) == 0); end
      else if (imem_req && imem_addr !== 32'(4 * (c / 2))) begin errors++; $display("FAIL basic_addr c%0d: got %h want %h", c, imem_addr, 4 * (c / 2)); end
      if (c == 2) begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL basic_first: valid %b pc %h want 1 0", instr_valid, instr_pc); end
        checks++; if (instr !== w) begin errors++; $display("FAIL basic_instr: got %h want %h", instr, w); end
        checks++; if (opcode !== w[6:0] || funct3 !== w[14:12] || funct7_5 !== w[30]) begin errors++; $display("FAIL basic_fields: got %h %h %b want %h %h %b", opcode, funct3, funct7_5, w[6:0], w[14:12], w[30]); end
      end
      end_cycle();
    end
    checks++;
    if (got_pc.size() != 3 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 || got_pc[2] !== 32'h8) begin
      errors++; $display("FAIL basic_seq: %0d pops, want 0,4,8", got_pc.size());
    end
  endtask

  task automatic test_backpressure();
    mem_lat = 1; instr_ready = 1'b0; imem_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      begin_cycle();
      if (c >= 4) begin
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL bp_full c%0d: req %b valid %b pc %h want 0 1 0", c, imem_req, instr_valid, instr_pc); end
      end
      end_cycle();
    end
    instr_ready = 1'b1;
    begin_cycle();
    checks++; if (instr_pc !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL bp_pop0: pc %h req %b want 0 0", instr_pc, imem_req); end
    end_cycle();
    begin_cycle();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin errors++; $display("FAIL bp_pop1: valid %b pc %h want 1 4", instr_valid, instr_pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL bp_resume: req %b addr %h want 1 8", imem_req, imem_addr); end
    end_cycle();
    checks++; if (got_pc.size() != 2 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4) begin errors++; $display("FAIL bp_seq: %0d pops, want 0,4", got_pc.size()); end
  endtask

  task automatic test_redirect_empty();
    mem_lat = 1; instr_ready = 1'b1; imem_ready = 1'b1;
    do_reset();
    pc_src = 1'b1; pc_target = 32'h0000_0103;
    begin_cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_e_req: got %b want 0", imem_req); end
    end_cycle();
    pc_src = 1'b0;
    begin_cycle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin errors++; $display("FAIL redir_e_target: req %b addr %h valid %b want 1 100 0", imem_req, imem_addr, instr_valid); end
    end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin errors++; $display("FAIL redir_e_instr: valid %b pc %h instr %h want 1 100 %h", instr_valid, instr_pc, instr, mem_word(32'h100)); end
    end_cycle();
  endtask

  task automatic test_redirect_outstanding();
    bit bad;
    mem_lat = 3; instr_ready = 1'b0; imem_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 4; c++) begin begin_cycle(); end_cycle(); end
    begin_cycle();
    checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL redir_o_setup: valid %b req %b addr %h want 1 1 4", instr_valid, imem_req, imem_addr); end
    end_cycle();
    pc_src = 1'b1; pc_target = 32'h0000_0200;
    begin_cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_o_req: got %b want 0", imem_req); end
    end_cycle();
    pc_src = 1'b0;
    begin_cycle();
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL redir_o_flush: valid %b req %b want 0 0", instr_valid, imem_req); end
    end_cycle();
    begin_cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_o_wait: req %b want 0", imem_req); end
    end_cycle();
    begin_cycle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin errors++; $display("FAIL redir_o_target: req %b addr %h valid %b want 1 200 0", imem_req, imem_addr, instr_valid); end
    end_cycle();
    instr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin begin_cycle(); end_cycle(); end
    bad = (got_pc.size() == 0);
    foreach (got_pc[i]) if (got_pc[i] < 32'h200) bad = 1'b1;
    checks++; if (bad || got_pc[0] !== 32'h200) begin errors++; $display("FAIL redir_o_stale: %0d pops, first %h want 200 and none below", got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx); end
  endtask

  task automatic test_simultaneous();
    mem_lat = 1; instr_ready = 1'b0; imem_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 3; c++) begin begin_cycle(); end_cycle(); end
    instr_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h0000_0300;
    begin_cycle();
    checks++; if (imem_rvalid !== 1'b1 || instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL simul_edge: rvalid %b valid %b pc %h req %b want 1 1 0 0", imem_rvalid, instr_valid, instr_pc, imem_req); end
    end_cycle();
    pc_src = 1'b0;
    begin_cycle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0) begin errors++; $display("FAIL simul_target: req %b addr %h valid %b want 1 300 0", imem_req, imem_addr, instr_valid); end
    end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin errors++; $display("FAIL simul_nodrop: valid %b pc %h want 1 300", instr_valid, instr_pc); end
    end_cycle();
    checks++; if (got_pc.size() != 2 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h300) begin errors++; $display("FAIL simul_seq: %0d pops, want 0,300", got_pc.size()); end
  endtask

  task automatic test_wrap_and_reset();
    mem_lat = 1; instr_ready = 1'b1; imem_ready = 1'b1;
    do_reset();
    pc_src = 1'b1; pc_target = 32'hFFFF_FFFF;
    begin_cycle(); end_cycle();
    pc_src = 1'b0;
    begin_cycle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: req %b addr %h want 1 fffffffc", imem_req, imem_addr); end
    end_cycle();
    begin_cycle(); end_cycle();
    mem_lat = 3;
    begin_cycle();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr: valid %b pc %h want 1 fffffffc", instr_valid, instr_pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero: req %b addr %h want 1 0", imem_req, imem_addr); end
    end_cycle();
    rst = 1'b1;
    begin_cycle();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL midrst_outs: req %b valid %b addr %h instr %h pc %h want 0", imem_req, instr_valid, imem_addr, instr, instr_pc); end
    end_cycle();
    begin_cycle(); end_cycle();
    rst = 1'b0;
    begin_cycle();
    checks++; if (imem_rvalid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_restart: rvalid %b req %b addr %h want 1 1 0", imem_rvalid, imem_req, imem_addr); end
    end_cycle();
    begin_cycle();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_late: valid %b want 0", instr_valid); end
    end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin errors++; $display("FAIL midrst_fetch: valid %b pc %h instr %h want 1 0 %h", instr_valid, instr_pc, instr, mem_word(32'h0)); end
    end_cycle();
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    pc_src = 1'b0; pc_target = 32'h0; instr_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_empty();
    test_redirect_outstanding();
    test_simultaneous();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
